spi_byte_master: RTL and testbench



---
 rtl/spi_byte_master_if.sv | 24 ++
 rtl/spi_byte_master.sv | 188 ++++++++++++++++++
 tb/tb_spi_byte_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_master_if.sv
// Byte handshake and SPI pin bundle for spi_byte_master; the design takes the slave modport,
// the user logic and the SPI pins together form the master side.
interface spi_byte_master_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       SCLK;
   logic       MOSI;
   logic       MISO;
   logic       SS;

   modport slave (
      input  tx_valid, tx_data, MISO,
      output tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, SS
   );

   modport master (
      output tx_valid, tx_data, MISO,
      input  tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, SS
   );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: one byte per SS frame, tx_ready back 1+CS_SETUP+17*CLK_DIV+CS_GAP cycles after accept;
// tx_valid is ignored while tx_ready is low. SPI_BYTE_MASTER_BURST_EN chains bytes inside one SS low period.
module spi_byte_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_GAP   = 2
) (
   input logic               clk,
   input logic               reset_n,
   spi_byte_master_if.slave  bus
);

   generate
      if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
         $error("CLK_DIV must be in 2..255");
      end
      if (CS_SETUP < 1 || CS_SETUP > 255) begin : g_bad_cs_setup
         $error("CS_SETUP must be in 1..255");
      end
      if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
         $error("CS_GAP must be in 1..255");
      end
   endgenerate

   localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
   localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] div_cnt, div_nxt;
   logic [2:0] bit_cnt, bit_nxt;
   logic       sclk_q, sclk_nxt;
   logic       ss_q, ss_nxt;
   logic       ready_q, ready_nxt;
   logic       rxv_q, rxv_nxt;
   logic       samp_q, samp_nxt;
   logic [7:0] tx_sh, tx_nxt;
   logic [7:0] rx_sh, rx_sh_nxt;
   logic [7:0] rx_q, rx_nxt;
   logic       div_zero;
   logic       hold_last;
   logic       accept;

   assign div_zero  = (div_cnt == 8'd0);
   assign hold_last = (state == HOLD) && div_zero;

   // ready_q lags IDLE by one cycle, so reset release and frame end both reopen a cycle late
`ifdef SPI_BYTE_MASTER_BURST_EN
   assign bus.tx_ready = ready_q | hold_last;
`else
   assign bus.tx_ready = ready_q;
`endif

   assign accept = bus.tx_valid & bus.tx_ready;

   always_comb begin
      state_nxt = state;
      div_nxt   = div_zero ? div_cnt : div_cnt - 8'd1;
      bit_nxt   = bit_cnt;
      sclk_nxt  = sclk_q;
      ss_nxt    = ss_q;
      ready_nxt = (state == IDLE) && !accept;
      rxv_nxt   = 1'b0;
      samp_nxt  = 1'b0;
      tx_nxt    = tx_sh;
      rx_sh_nxt = samp_q ? {rx_sh[6:0], bus.MISO} : rx_sh;
      rx_nxt    = rx_q;

      case (state)
         IDLE: begin
            ss_nxt   = 1'b1;
            sclk_nxt = 1'b0;
            if (accept) begin
               state_nxt = SETUP;
               ss_nxt    = 1'b0;
               tx_nxt    = bus.tx_data;
               div_nxt   = SETUP_LD;
            end
         end

         SETUP: begin
            if (div_zero) begin
               state_nxt = SHIFT;
               div_nxt   = DIV_LD;
               bit_nxt   = 3'd0;
            end
         end

         SHIFT: begin
            if (div_zero) begin
               div_nxt = DIV_LD;
               if (!sclk_q) begin
                  sclk_nxt = 1'b1;
                  samp_nxt = 1'b1;
               end else begin
                  sclk_nxt = 1'b0;
                  if (bit_cnt == 3'd7) begin
                     state_nxt = HOLD;
                  end else begin
                     bit_nxt = bit_cnt + 3'd1;
                     tx_nxt  = {tx_sh[6:0], 1'b0};
                  end
               end
            end
         end

         HOLD: begin
            if (hold_last) begin
               rxv_nxt = 1'b1;
               rx_nxt  = rx_sh;
`ifdef SPI_BYTE_MASTER_BURST_EN
               if (accept) begin
                  state_nxt = SHIFT;
                  tx_nxt    = bus.tx_data;
                  div_nxt   = DIV_LD;
                  bit_nxt   = 3'd0;
               end else begin
                  state_nxt = GAP;
                  ss_nxt    = 1'b1;
                  div_nxt   = GAP_LD;
               end
`else
               state_nxt = GAP;
               ss_nxt    = 1'b1;
               div_nxt   = GAP_LD;
`endif
            end
         end

         GAP: begin
            if (div_zero) begin
               state_nxt = IDLE;
               tx_nxt    = 8'h00;
            end
         end

         default: begin
            state_nxt = IDLE;
            ss_nxt    = 1'b1;
            sclk_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         div_cnt <= 8'd0;
         bit_cnt <= 3'd0;
         sclk_q  <= 1'b0;
         ss_q    <= 1'b1;
         ready_q <= 1'b0;
         rxv_q   <= 1'b0;
         samp_q  <= 1'b0;
         tx_sh   <= 8'h00;
         rx_sh   <= 8'h00;
         rx_q    <= 8'h00;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         sclk_q  <= sclk_nxt;
         ss_q    <= ss_nxt;
         ready_q <= ready_nxt;
         rxv_q   <= rxv_nxt;
         samp_q  <= samp_nxt;
         tx_sh   <= tx_nxt;
         rx_sh   <= rx_sh_nxt;
         rx_q    <= rx_nxt;
      end
   end

   assign bus.SCLK     = sclk_q;
   assign bus.SS       = ss_q;
   assign bus.MOSI     = tx_sh[7];
   assign bus.rx_valid = rxv_q;
   assign bus.rx_data  = rx_q;
   assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master at CLK_DIV=2, CS_SETUP=2, CS_GAP=2 with a mode-0 slave model on MISO.
module tb_spi_byte_master;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   fails  = 0;

   spi_byte_master_if bus();

   spi_byte_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_GAP(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #4 clk = ~clk;

   // slave model: first bit valid at SS fall, next bit after each SCLK fall
   logic [7:0] resp = 8'h00;
   logic       miso_stuck = 1'b0;
   int         miso_idx = 0;
   bit         armed = 1'b0;
   always @(bus.SS or negedge bus.SCLK) begin
      if (bus.SS !== 1'b0) begin
         miso_idx = 0;
         armed    = 1'b0;
      end else if (!armed) begin
         armed    = 1'b1;
         miso_idx = 0;
      end else begin
         miso_idx++;
      end
      bus.MISO = miso_stuck | resp[3'(7 - miso_idx)];
   end

   int         rises = 0, ss_falls = 0, rxv_cnt = 0, mosi_viol = 0, high_run = 0, last_gap = 0;
   logic [7:0] mosi_bits = 8'h00;
   logic       prev_sclk = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;
   always @(negedge clk) begin
      if (bus.SCLK === 1'b1 && prev_sclk === 1'b0) begin
         rises++;
         mosi_bits = {mosi_bits[6:0], bus.MOSI};
      end
      if (bus.SCLK === 1'b1 && prev_sclk === 1'b1 && bus.MOSI !== prev_mosi) mosi_viol++;
      if (bus.SS === 1'b0 && prev_ss === 1'b1) begin
         ss_falls++;
         last_gap = high_run;
      end
      high_run = (bus.SS === 1'b1) ? high_run + 1 : 0;
      if (bus.rx_valid === 1'b1) rxv_cnt++;
      prev_sclk = bus.SCLK;
      prev_ss   = bus.SS;
      prev_mosi = bus.MOSI;
   end

   task automatic send(input logic [7:0] d, output int cyc, output logic [3:0] snap);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.tx_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.tx_ready !== 1'b1) begin
         checks++; fails++;
         $display("FAIL send_ready_timeout: tx_ready=%b required 1", bus.tx_ready);
      end
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      snap = {bus.SS, bus.SCLK, bus.MOSI, bus.tx_ready};
      cyc = 0;
      while (cyc < 400) begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus.tx_ready === 1'b1 && bus.busy === 1'b0) break;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.SS !== 1'b1) begin fails++; $display("FAIL reset_ss: got %b required 1", bus.SS); end
      checks++; if (bus.SCLK !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b required 0", bus.SCLK); end
      checks++; if (bus.MOSI !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b required 0", bus.MOSI); end
      checks++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL reset_tx_ready: got %b required 0", bus.tx_ready); end
      checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b required 0", bus.rx_valid); end
      checks++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h required 00", bus.rx_data); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL release_ready_early: got %b required 0", bus.tx_ready); end
      @(posedge clk); #1;
      checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL release_ready_first_edge: got %b required 1", bus.tx_ready); end
   endtask

   task automatic test_single();
      int cyc, r0, v0;
      logic [3:0] snap;
      resp = 8'h3C;
      r0 = rises; v0 = rxv_cnt;
      send(8'hA5, cyc, snap);
      checks++; if (snap !== 4'b0010) begin fails++; $display("FAIL single_after_accept {SS,SCLK,MOSI,rdy}: got %b required 0010", snap); end
      checks++; if (cyc !== 39) begin fails++; $display("FAIL single_frame_cycles: got %0d required 39", cyc); end
      checks++; if (rises - r0 !== 8) begin fails++; $display("FAIL single_sclk_rises: got %0d required 8", rises - r0); end
      checks++; if (mosi_bits !== 8'hA5) begin fails++; $display("FAIL single_mosi: got %h required a5", mosi_bits); end
      checks++; if (bus.rx_data !== 8'h3C) begin fails++; $display("FAIL single_rx_data: got %h required 3c", bus.rx_data); end
      checks++; if (rxv_cnt - v0 !== 1) begin fails++; $display("FAIL single_rx_valid_cycles: got %0d required 1", rxv_cnt - v0); end
      checks++; if (mosi_viol !== 0) begin fails++; $display("FAIL single_mosi_stable_high: got %0d changes required 0", mosi_viol); end
      repeat (6) @(negedge clk);
      checks++; if (bus.rx_data !== 8'h3C) begin fails++; $display("FAIL single_rx_hold: got %h required 3c", bus.rx_data); end
   endtask

`ifdef SPI_BYTE_MASTER_BURST_EN
   task automatic test_burst();
      int r0, v0, f0, n;
      logic [7:0] bytes [3];
      bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
      resp = 8'hA7;
      r0 = rises; v0 = rxv_cnt; f0 = ss_falls;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.tx_data = bytes[i];
         n = 0;
         @(negedge clk);
         while (bus.tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
         @(posedge clk); #1;
      end
      bus.tx_valid = 1'b0;
      n = 0;
      while (!(bus.tx_ready === 1'b1 && bus.busy === 1'b0) && n < 400) begin @(posedge clk); #1; n++; end
      checks++; if (ss_falls - f0 !== 1) begin fails++; $display("FAIL burst_ss_falls: got %0d required 1", ss_falls - f0); end
      checks++; if (rises - r0 !== 24) begin fails++; $display("FAIL burst_sclk_rises: got %0d required 24", rises - r0); end
      checks++; if (rxv_cnt - v0 !== 3) begin fails++; $display("FAIL burst_rx_valid: got %0d required 3", rxv_cnt - v0); end
      checks++; if (mosi_bits !== 8'h56) begin fails++; $display("FAIL burst_last_mosi: got %h required 56", mosi_bits); end
      checks++; if (bus.rx_data !== 8'hA7) begin fails++; $display("FAIL burst_rx_data: got %h required a7", bus.rx_data); end
   endtask
`else
   task automatic test_back_to_back();
      int r0, v0, f0, n;
      resp = 8'h81;
      r0 = rises; v0 = rxv_cnt; f0 = ss_falls;
      n = 0;
      @(negedge clk);
      while (bus.tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h01;
      @(posedge clk); #1;
      bus.tx_data  = 8'hFF;
      n = 0;
      @(negedge clk);
      while (bus.tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      n = 0;
      while (!(bus.tx_ready === 1'b1 && bus.busy === 1'b0) && n < 400) begin @(posedge clk); #1; n++; end
      checks++; if (ss_falls - f0 !== 2) begin fails++; $display("FAIL b2b_ss_falls: got %0d required 2", ss_falls - f0); end
      checks++; if (last_gap !== 4) begin fails++; $display("FAIL b2b_ss_gap: got %0d required 4", last_gap); end
      checks++; if (rxv_cnt - v0 !== 2) begin fails++; $display("FAIL b2b_rx_valid: got %0d required 2", rxv_cnt - v0); end
      checks++; if (rises - r0 !== 16) begin fails++; $display("FAIL b2b_sclk_rises: got %0d required 16", rises - r0); end
      checks++; if (mosi_bits !== 8'hFF) begin fails++; $display("FAIL b2b_mosi: got %h required ff", mosi_bits); end
      checks++; if (bus.rx_data !== 8'h81) begin fails++; $display("FAIL b2b_rx_data: got %h required 81", bus.rx_data); end
   endtask
`endif

   task automatic test_busy_ignore();
      int r0, v0, f0, n;
      resp = 8'h0F;
      r0 = rises; v0 = rxv_cnt; f0 = ss_falls;
      n = 0;
      @(negedge clk);
      while (bus.tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h3C;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'hEE;
      repeat (4) @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bus.tx_valid = ~bus.tx_valid;
      end
      bus.tx_valid = 1'b0;
      n = 0;
      while (!(bus.tx_ready === 1'b1 && bus.busy === 1'b0) && n < 400) begin @(posedge clk); #1; n++; end
      repeat (10) @(negedge clk);
      checks++; if (mosi_bits !== 8'h3C) begin fails++; $display("FAIL ignore_mosi: got %h required 3c", mosi_bits); end
      checks++; if (ss_falls - f0 !== 1) begin fails++; $display("FAIL ignore_frames: got %0d required 1", ss_falls - f0); end
      checks++; if (rises - r0 !== 8) begin fails++; $display("FAIL ignore_sclk_rises: got %0d required 8", rises - r0); end
      checks++; if (rxv_cnt - v0 !== 1) begin fails++; $display("FAIL ignore_rx_valid: got %0d required 1", rxv_cnt - v0); end
      checks++; if (bus.rx_data !== 8'h0F) begin fails++; $display("FAIL ignore_rx_data: got %h required 0f", bus.rx_data); end
   endtask

   task automatic test_reset_mid();
      int r0, v0, n, cyc;
      logic [3:0] snap;
      resp = 8'h99;
      r0 = rises; v0 = rxv_cnt;
      n = 0;
      @(negedge clk);
      while (bus.tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h77;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      n = 0;
      while (rises - r0 < 4 && n < 300) begin @(negedge clk); n++; end
      checks++; if (bus.SCLK !== 1'b1) begin fails++; $display("FAIL midreset_pre_sclk: got %b required 1", bus.SCLK); end
      reset_n = 1'b0;
      #1;
      checks++; if (bus.SS !== 1'b1) begin fails++; $display("FAIL midreset_ss: got %b required 1", bus.SS); end
      checks++; if (bus.SCLK !== 1'b0) begin fails++; $display("FAIL midreset_sclk: got %b required 0", bus.SCLK); end
      checks++; if (bus.MOSI !== 1'b0) begin fails++; $display("FAIL midreset_mosi: got %b required 0", bus.MOSI); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b required 0", bus.busy); end
      checks++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL midreset_tx_ready: got %b required 0", bus.tx_ready); end
      checks++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL midreset_rx_data: got %h required 00", bus.rx_data); end
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (rxv_cnt - v0 !== 0) begin fails++; $display("FAIL midreset_no_rx_valid: got %0d required 0", rxv_cnt - v0); end
      resp = 8'hC3;
      r0 = rises;
      send(8'h5A, cyc, snap);
      checks++; if (cyc !== 39) begin fails++; $display("FAIL postreset_cycles: got %0d required 39", cyc); end
      checks++; if (rises - r0 !== 8) begin fails++; $display("FAIL postreset_sclk_rises: got %0d required 8", rises - r0); end
      checks++; if (mosi_bits !== 8'h5A) begin fails++; $display("FAIL postreset_mosi: got %h required 5a", mosi_bits); end
      checks++; if (bus.rx_data !== 8'hC3) begin fails++; $display("FAIL postreset_rx_data: got %h required c3", bus.rx_data); end
      checks++; if (rxv_cnt - v0 !== 1) begin fails++; $display("FAIL postreset_rx_valid: got %0d required 1", rxv_cnt - v0); end
   endtask

   task automatic test_boundaries();
      int cyc, r0;
      logic [3:0] snap;
      logic [7:0] pat [2];
      pat[0] = 8'h00; pat[1] = 8'hFF;
      resp = 8'h00;
      miso_stuck = 1'b1;
      for (int i = 0; i < 2; i++) begin
         r0 = rises;
         send(pat[i], cyc, snap);
         checks++; if (bus.rx_data !== 8'hFF) begin fails++; $display("FAIL bound_rx_data[%0d]: got %h required ff", i, bus.rx_data); end
         checks++; if (rises - r0 !== 8) begin fails++; $display("FAIL bound_sclk_rises[%0d]: got %0d required 8", i, rises - r0); end
         checks++; if (mosi_bits !== pat[i]) begin fails++; $display("FAIL bound_mosi[%0d]: got %h required %h", i, mosi_bits, pat[i]); end
      end
      miso_stuck = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
`ifdef SPI_BYTE_MASTER_BURST_EN
      test_burst();
`else
      test_back_to_back();
`endif
      test_busy_ignore();
      test_reset_mid();
      test_boundaries();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
